// File: rtl/speck_uart_pkg.sv
// rtl/speck_uart_pkg.sv - byte codes, state encoding and sizing helper for the SPECK UART link
package speck_uart_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_RX_PAY   = 4'd1,
    ST_KS_WAIT  = 4'd2,
    ST_OP_WAIT  = 4'd3,
    ST_DONE_CLR = 4'd4,
    ST_TX_BYTE  = 4'd5,
    ST_TX_WAIT  = 4'd6,
    ST_SRST     = 4'd7
  } state_e;

  localparam logic [7:0] CMD_KEY     = 8'h4B;
  localparam logic [7:0] CMD_ENC     = 8'h45;
  localparam logic [7:0] CMD_DEC     = 8'h44;
  localparam logic [7:0] CMD_RST     = 8'h52;
  localparam logic [7:0] RSP_UNKNOWN = 8'h3F;
  localparam logic [7:0] RSP_NOKEY   = 8'h21;
  localparam logic [7:0] RSP_TIMEOUT = 8'h54;
  localparam logic [7:0] RSP_KEY_OK  = 8'h6B;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/speck_uart_tx_serializer.sv
// rtl/speck_uart_tx_serializer.sv - sends a loaded word MSB-first, one byte per tx_valid/tx_busy handshake
module speck_uart_tx_serializer #(
  parameter int W   = 32,
  parameter int NBW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic [2*W-1:0] word_i,
  input  logic [NBW-1:0] nbytes_i,
  input  logic           fire_i,
  input  logic           tx_busy_i,
  output logic [7:0]     tx_data_o,
  output logic           tx_valid_o,
  output logic           byte_done_o,
  output logic           last_o
);

  logic [2*W-1:0] sh_q;
  logic [NBW-1:0] cnt_q;
  logic [7:0]     data_q;
  logic           valid_q;
  logic           pend_q;
  logic           seen_q;

  // A byte is finished only once busy has been seen high and has dropped again.
  assign byte_done_o = pend_q && seen_q && !tx_busy_i;
  assign last_o      = (cnt_q == NBW'(1));
  assign tx_data_o   = data_q;
  assign tx_valid_o  = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      valid_q <= fire_i;
      if (load_i) begin
        sh_q   <= word_i;
        cnt_q  <= nbytes_i;
        pend_q <= 1'b0;
        seen_q <= 1'b0;
      end else if (fire_i) begin
        data_q <= sh_q[2*W-1 -: 8];
        pend_q <= 1'b1;
        seen_q <= 1'b0;
      end else if (byte_done_o) begin
        sh_q   <= sh_q << 8;
        cnt_q  <= cnt_q - NBW'(1);
        pend_q <= 1'b0;
        seen_q <= 1'b0;
      end else if (pend_q && tx_busy_i) begin
        seen_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/speck_uart_cmd_link.sv
// rtl/speck_uart_cmd_link.sv - UART command/frame engine for SPECK key schedule and cipher cores
module speck_uart_cmd_link
  import speck_uart_pkg::*;
#(
  parameter int W           = 32,
  parameter int M           = 4,
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int RST_CYCLES  = 1000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [7:0]     rx_data_i,
  input  logic           rx_valid_i,
  output logic [7:0]     tx_data_o,
  output logic           tx_valid_o,
  input  logic           tx_busy_i,
  output logic [M*W-1:0] key_flat_o,
  output logic           key_load_o,
  input  logic           ks_done_i,
  output logic [2*W-1:0] blk_in_o,
  output logic           op_start_o,
  output logic           op_decrypt_o,
  input  logic [2*W-1:0] blk_out_i,
  input  logic           op_done_i,
  output logic           soft_rst_o,
  output logic           busy_o,
  output logic [7:0]     err_cnt_o,
  output logic [3:0]     state_out_o
);

  localparam int KW  = M * W;
  localparam int KB  = KW / 8;
  localparam int BB  = 2 * W / 8;
  localparam int CW  = clog2(KB + 1);
  localparam int NBW = clog2(BB + 1);
  localparam int TW  = clog2(TIMEOUT_CYC + 1);
  localparam int RW  = clog2(RST_CYCLES + 1);
  localparam logic [CW-1:0] KEY_BYTES = CW'(KB);
  localparam logic [CW-1:0] BLK_BYTES = CW'(BB);

  state_e         state_q, state_d;
  logic [7:0]     cmd_q, cmd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]  to_q, to_d;
  logic [RW-1:0]  rc_q, rc_d;
  logic [KW-1:0]  pay_q, pay_d;
  logic [KW-1:0]  key_q, key_d;
  logic [2*W-1:0] blk_q, blk_d;
  logic           kv_q, kv_d;
  logic           dec_q, dec_d;
  logic [7:0]     err_q, err_d;
  logic           key_load_q, key_load_d;
  logic           op_start_q, op_start_d;

  logic           ser_load, ser_fire, ser_byte_done, ser_last;
  logic [2*W-1:0] ser_word;
  logic [NBW-1:0] ser_n;
  logic           rsp_en, err_inc;
  logic [7:0]     rsp_code;

  speck_uart_tx_serializer #(.W(W), .NBW(NBW)) u_ser (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (ser_load),
    .word_i      (ser_word),
    .nbytes_i    (ser_n),
    .fire_i      (ser_fire),
    .tx_busy_i   (tx_busy_i),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .byte_done_o (ser_byte_done),
    .last_o      (ser_last)
  );

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    rc_d       = rc_q;
    pay_d      = pay_q;
    key_d      = key_q;
    blk_d      = blk_q;
    kv_d       = kv_q;
    dec_d      = dec_q;
    key_load_d = 1'b0;
    op_start_d = 1'b0;
    ser_load   = 1'b0;
    ser_word   = '0;
    ser_n      = '0;
    ser_fire   = 1'b0;
    rsp_en     = 1'b0;
    rsp_code   = '0;
    err_inc    = 1'b0;
    case (state_q)
      ST_IDLE: if (rx_valid_i) begin
        if (rx_data_i == CMD_KEY || rx_data_i == CMD_ENC || rx_data_i == CMD_DEC) begin
          cmd_d   = rx_data_i;
          cnt_d   = '0;
          to_d    = '0;
          state_d = ST_RX_PAY;
        end else if (rx_data_i == CMD_RST) begin
          rc_d    = '0;
          kv_d    = 1'b0;
          state_d = ST_SRST;
        end else begin
          rsp_en   = 1'b1;
          rsp_code = RSP_UNKNOWN;
          err_inc  = 1'b1;
        end
      end
      ST_RX_PAY: begin
        // Payload is staged so key/block outputs only change on a complete frame.
        if (cnt_q == ((cmd_q == CMD_KEY) ? KEY_BYTES : BLK_BYTES)) begin
          err_inc = rx_valid_i;
          if (cmd_q == CMD_KEY) begin
            key_d      = pay_q;
            kv_d       = 1'b0;
            key_load_d = 1'b1;
            state_d    = ST_KS_WAIT;
          end else if (kv_q) begin
            blk_d      = pay_q[2*W-1:0];
            dec_d      = (cmd_q == CMD_DEC);
            op_start_d = 1'b1;
            state_d    = ST_OP_WAIT;
          end else begin
            rsp_en   = 1'b1;
            rsp_code = RSP_NOKEY;
            err_inc  = 1'b1;
          end
        end else if (rx_valid_i) begin
          pay_d = {pay_q[KW-9:0], rx_data_i};
          cnt_d = cnt_q + CW'(1);
          to_d  = '0;
        end else if (to_q == TW'(TIMEOUT_CYC - 1)) begin
          rsp_en   = 1'b1;
          rsp_code = RSP_TIMEOUT;
          err_inc  = 1'b1;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      ST_KS_WAIT: if (ks_done_i) begin
        kv_d     = 1'b1;
        ser_load = 1'b1;
        ser_word = {RSP_KEY_OK, {(2*W-8){1'b0}}};
        ser_n    = NBW'(1);
        state_d  = ST_DONE_CLR;
      end
      ST_OP_WAIT: if (op_done_i) begin
        ser_load = 1'b1;
        ser_word = blk_out_i;
        ser_n    = NBW'(BB);
        state_d  = ST_DONE_CLR;
      end
      ST_DONE_CLR: if (!((cmd_q == CMD_KEY) ? ks_done_i : op_done_i)) state_d = ST_TX_BYTE;
      ST_TX_BYTE: if (!tx_busy_i) begin
        ser_fire = 1'b1;
        state_d  = ST_TX_WAIT;
      end
      ST_TX_WAIT: if (ser_byte_done) state_d = ser_last ? ST_IDLE : ST_TX_BYTE;
      ST_SRST: begin
        if (rc_q == RW'(RST_CYCLES - 1)) state_d = ST_IDLE;
        else rc_d = rc_q + RW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    if (rsp_en) begin
      ser_load = 1'b1;
      ser_word = {rsp_code, {(2*W-8){1'b0}}};
      ser_n    = NBW'(1);
      state_d  = ST_TX_BYTE;
    end
    // Bytes arriving while the engine is occupied are dropped as overruns.
    if (rx_valid_i && state_q != ST_IDLE && state_q != ST_RX_PAY) err_inc = 1'b1;
    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      cnt_q      <= '0;
      to_q       <= '0;
      rc_q       <= '0;
      pay_q      <= '0;
      key_q      <= '0;
      blk_q      <= '0;
      kv_q       <= 1'b0;
      dec_q      <= 1'b0;
      err_q      <= '0;
      key_load_q <= 1'b0;
      op_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      rc_q       <= rc_d;
      pay_q      <= pay_d;
      key_q      <= key_d;
      blk_q      <= blk_d;
      kv_q       <= kv_d;
      dec_q      <= dec_d;
      err_q      <= err_d;
      key_load_q <= key_load_d;
      op_start_q <= op_start_d;
    end
  end

  assign key_flat_o   = key_q;
  assign key_load_o   = key_load_q;
  assign blk_in_o     = blk_q;
  assign op_start_o   = op_start_q;
  assign op_decrypt_o = dec_q;
  assign soft_rst_o   = (state_q == ST_SRST);
  assign busy_o       = (state_q != ST_IDLE);
  assign err_cnt_o    = err_q;
  assign state_out_o  = state_q;

endmodule
